counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Downstream consumer of the 4-bit up/down/load counter scoreboard.
- Each enabled cycle, compares the scoreboard's expected count/ripple-carry (sb_Q, sb_rco) against the counter DUT's outputs (dut_Q, dut_rco).
- Counts checks and mismatches, captures the first mismatch, and raises a sticky fail flag after MAX_ERR mismatches.
- Sits in the testbench between the scoreboard/DUT pair and the monitor/report logic.

Parameters:
- WIDTH, 4, width of Q compared.
- LAT, 0, extra cycles by which DUT outputs lag the scoreboard. Legal range 0..3; the scoreboard side is delayed LAT cycles to align.
- ERR_W, 8, width of the error counter.
- MAX_ERR, 1, mismatch count at which fail asserts. Legal range 1..2^ERR_W-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- enable  input  1  same enable driven to scoreboard and DUT.
- modo  input  2  same mode driven to scoreboard and DUT (00 +1, 01 -1, 10 -3, 11 load).
- sb_Q  input  WIDTH  scoreboard expected count.
- sb_rco  input  1  scoreboard expected ripple-carry.
- dut_Q  input  WIDTH  DUT count.
- dut_rco  input  1  DUT ripple-carry.
- clr_err  input  1  synchronous clear of counters, capture and fail; does not clear the alignment pipeline.
- state  output  2  00 IDLE, 01 CHECK, 10 FAIL.
- mismatch  output  1  one-cycle pulse, registered.
- chk_cnt  output  16  checks performed, saturating at 16'hFFFF.
- err_cnt  output  ERR_W  mismatches, saturating at all-ones.
- first_valid  output  1  first-mismatch capture holds data.
- first_exp  output  WIDTH+1  {sb_rco, sb_Q} at first mismatch.
- first_got  output  WIDTH+1  {dut_rco, dut_Q} at first mismatch.
- first_modo  output  2  modo associated with first mismatch.
- fail  output  1  sticky; high in FAIL.

Behaviour:
- Reset (reset==0 at posedge), which has priority over everything:
  - state=IDLE; mismatch=0; chk_cnt=0; err_cnt=0; first_valid=0; first_exp=0; first_got=0; first_modo=0; fail=0.
  - Alignment pipeline valid bits cleared; pipeline data bits don't-care.
  - A reset mid-run discards all in-flight samples.
- Update flag: upd <= enable each posedge. upd==1 means sb/dut outputs were updated at the previous edge and are now checkable. The modo paired with upd is modo registered alongside it.
- Alignment pipeline:
  - Depth LAT, shifting {upd, modo_r, sb_rco, sb_Q} every posedge.
  - The tap (the pipeline input itself when LAT=0) gives exp_v, exp_modo, exp.
  - The DUT side is never delayed.
- Compare event occurs at a posedge when exp_v==1 and reset==1 and clr_err==0.
  - neq = ({dut_rco,dut_Q} != exp); full-width compare in all modes, including rco in mode 11.
  - chk_cnt += 1, saturating.
  - If neq: mismatch<=1 for exactly the next cycle; err_cnt += 1, saturating.
  - If neq and first_valid==0: capture first_exp/first_got/first_modo and set first_valid. Later mismatches never overwrite the capture.
  - If no compare event: mismatch<=0.
- FSM (registered):
  - IDLE -> CHECK on the first compare event. That same compare is counted and may mismatch.
  - CHECK -> FAIL when the err_cnt next-value >= MAX_ERR. fail asserts in the same cycle state becomes FAIL, i.e. one cycle after the offending sample.
  - FAIL is sticky. Compares, counting and mismatch pulses continue; the capture stays frozen.
  - FAIL/CHECK -> IDLE only via reset or clr_err.
- clr_err==1 (reset high):
  - Same clears as reset except the pipeline keeps shifting.
  - A mismatch present that cycle is dropped: not counted, no pulse.
- enable low:
  - No new samples enter. Pending pipeline samples still drain and are checked.
  - State holds; mismatch=0 once drained.
- Saturation: counters stick at max and never wrap; fail still asserts normally.

Test Plan:
- LAT=0, MAX_ERR=1: release reset, enable=1, modo=00, DUT tracks sb for 20 cycles. Required: chk_cnt=20, err_cnt=0, state=CHECK, fail=0.
- LAT=0: modo=00 with sb_Q=4'hF -> 0, sb_rco=1, but dut_rco forced 0 on that edge. Required: mismatch pulse 1 cycle later; err_cnt=1; first_exp=5'h10; first_got=5'h00; first_modo=00; state=FAIL; fail=1.
- LAT=2: DUT outputs delayed two cycles, modo=10 from Q=1 (expected 4'hE, rco=1). Required: no mismatch, and the first compare happens 3 edges after enable rises.
- MAX_ERR=3: inject mismatches on modo=11 loads D=5, then 9, then A. Required: fail on the 3rd only; first_exp holds the load-5 values after all three.
- clr_err coincident with a mismatch. Required: err_cnt=0, mismatch=0, first_valid=0, state=IDLE; the next good compare returns state to CHECK.
- reset=0 for one edge mid-run in FAIL with samples in flight (LAT=3). Required: all outputs zero/IDLE; the old pipeline samples are never compared.

Source files
------------

// File: rtl/counter_checker.sv
// counter_checker
// Compares a 4-bit up/down/load counter DUT against its scoreboard, one cycle
// at a time. It counts the checks and the mismatches, and it captures the first
// mismatch. After MAX_ERR mismatches it raises a sticky fail flag.
// The scoreboard side is delayed LAT cycles so that it lines up with the DUT.
//
// Ports
//   clk, reset             clock, synchronous active-low reset
//   enable, modo           enable/mode shared with scoreboard and DUT
//   sb_Q, sb_rco           scoreboard expected count / ripple-carry
//   dut_Q, dut_rco         DUT count / ripple-carry
//   clr_err                synchronous clear of counters, capture and fail
//   state                  00 IDLE, 01 CHECK, 10 FAIL
//   mismatch               registered one-cycle pulse per failed compare
//   chk_cnt, err_cnt       saturating check / mismatch counters
//   first_valid/exp/got/modo  first-mismatch capture
//   fail                   sticky, high while in FAIL
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no compare yet since reset / clr_err
// CHECK | compares running, mismatch count below MAX_ERR
// FAIL  | MAX_ERR reached; sticky until reset or clr_err
module counter_checker #(
   parameter int WIDTH   = 4,
   parameter int LAT     = 0,
   parameter int ERR_W   = 8,
   parameter int MAX_ERR = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       modo,
   input  logic [WIDTH-1:0] sb_Q,
   input  logic             sb_rco,
   input  logic [WIDTH-1:0] dut_Q,
   input  logic             dut_rco,
   input  logic             clr_err,
   output logic [1:0]       state,
   output logic             mismatch,
   output logic [15:0]      chk_cnt,
   output logic [ERR_W-1:0] err_cnt,
   output logic             first_valid,
   output logic [WIDTH:0]   first_exp,
   output logic [WIDTH:0]   first_got,
   output logic [1:0]       first_modo,
   output logic             fail
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CHECK = 2'b01,
      ST_FAIL  = 2'b10
   } state_t;

   localparam int PW = WIDTH + 4;   // {valid, modo[1:0], rco, Q}

   state_t           state_q, state_d;
   logic             upd;
   logic [1:0]       modo_r;
   logic [PW-1:0]    pipe_in, tap;
   logic             exp_v;
   logic [1:0]       exp_modo;
   logic [WIDTH:0]   exp_val, got_val;
   logic             cmp, neq;
   logic [ERR_W-1:0] err_d;

   // upd marks that sb/dut were updated at the previous edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         upd    <= 1'b0;
         modo_r <= 2'b00;
      end else begin
         upd    <= enable;
         modo_r <= modo;
      end
   end

   assign pipe_in = {upd, modo_r, sb_rco, sb_Q};

   // The pipeline keeps shifting through clr_err; only reset empties it.
   generate
      if (LAT == 0) begin : g_nodelay
         assign tap = pipe_in;
      end else begin : g_delay
         logic [PW-1:0] pipe [LAT];
         always_ff @(posedge clk) begin
            if (!reset) begin
               for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= pipe_in;
               for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign tap = pipe[LAT-1];
      end
   endgenerate

   assign {exp_v, exp_modo, exp_val} = tap;
   assign got_val = {dut_rco, dut_Q};
   assign cmp     = exp_v & ~clr_err;
   assign neq     = (got_val != exp_val);
   assign err_d   = (cmp && neq && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // When the very first compare already reaches MAX_ERR, IDLE goes straight
   // to FAIL. fail then still rises one cycle after the offending sample.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cmp) state_d = (err_d >= ERR_W'(MAX_ERR)) ? ST_FAIL : ST_CHECK;
         ST_CHECK: if (err_d >= ERR_W'(MAX_ERR)) state_d = ST_FAIL;
         ST_FAIL:  state_d = ST_FAIL;
         default:  state_d = ST_IDLE;
      endcase
      if (clr_err) state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset || clr_err) begin
         mismatch    <= 1'b0;
         chk_cnt     <= '0;
         err_cnt     <= '0;
         first_valid <= 1'b0;
         first_exp   <= '0;
         first_got   <= '0;
         first_modo  <= 2'b00;
      end else begin
         mismatch <= cmp & neq;
         err_cnt  <= err_d;
         if (cmp && (chk_cnt != 16'hFFFF)) chk_cnt <= chk_cnt + 16'd1;
         if (cmp && neq && !first_valid) begin
            first_valid <= 1'b1;
            first_exp   <= exp_val;
            first_got   <= got_val;
            first_modo  <= exp_modo;
         end
      end
   end

   assign state = state_q;
   assign fail  = (state_q == ST_FAIL);

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker. It drives three instances at once:
// (LAT0, MAX_ERR1), (LAT2, ERR_W2, MAX_ERR3) and (LAT3, MAX_ERR2).
// A small counter plays the scoreboard. Each DUT copy is a delayed and
// optionally corrupted history of it. The reference model keeps a
// queue of samples that come due at a given cycle.
module tb_counter_checker;
   localparam int NI = 3;
   localparam int LATS [NI] = '{0, 2, 3};
   localparam int EWS  [NI] = '{8, 2, 8};
   localparam int MAXS [NI] = '{1, 3, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, enable, clr_err, sb_rco;
   logic [1:0] modo;
   logic [3:0] sb_q, load_d;
   logic [3:0] dq   [NI];
   logic       drco [NI];

   logic [1:0]  st_o [NI];
   logic        mm_o [NI];
   logic [15:0] chk_o [NI];
   logic [7:0]  err_o [NI];
   logic        fv_o [NI];
   logic [4:0]  fe_o [NI];
   logic [4:0]  fg_o [NI];
   logic [1:0]  fm_o [NI];
   logic        fail_o [NI];

   generate
      for (genvar g = 0; g < NI; g++) begin : g_inst
         logic [EWS[g]-1:0] e;
         counter_checker #(.WIDTH(4), .LAT(LATS[g]), .ERR_W(EWS[g]), .MAX_ERR(MAXS[g])) u_dut (
            .clk(clk), .reset(reset), .enable(enable), .modo(modo),
            .sb_Q(sb_q), .sb_rco(sb_rco), .dut_Q(dq[g]), .dut_rco(drco[g]),
            .clr_err(clr_err), .state(st_o[g]), .mismatch(mm_o[g]),
            .chk_cnt(chk_o[g]), .err_cnt(e), .first_valid(fv_o[g]),
            .first_exp(fe_o[g]), .first_got(fg_o[g]), .first_modo(fm_o[g]),
            .fail(fail_o[g]));
         assign err_o[g] = 8'(e);
      end
   endgenerate

   // scoreboard history: value plus per-instance corruption of that sample
   typedef struct packed {
      logic [4:0]    v;
      logic [NI-1:0] cm;
      logic [4:0]    xm;
   } hist_t;
   hist_t         hist [4];
   logic [NI-1:0] nxt_cm;
   logic [4:0]    nxt_xm;

   typedef struct {
      int         due;
      logic [1:0] m;
      logic [4:0] v;
   } ent_t;
   ent_t pend [NI][$];

   int         cyc;
   logic       en_prev;
   logic [1:0] modo_prev;
   int         x_st [NI], x_chk [NI], x_err [NI];
   logic       x_mm [NI], x_fv [NI];
   logic [4:0] x_fe [NI], x_fg [NI];
   logic [1:0] x_fm [NI];
   int         n_vec, n_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_dut();
      logic [4:0] w;
      for (int k = 0; k < NI; k++) begin
         w = hist[LATS[k]].v ^ (hist[LATS[k]].cm[k] ? hist[LATS[k]].xm : 5'h00);
         {drco[k], dq[k]} = w;
      end
   endtask

   // Reference: a sample entering at cycle c is checked at cycle c+LAT.
   task automatic model_step();
      ent_t e;
      bit   hit;
      logic [4:0] got;
      for (int k = 0; k < NI; k++) begin
         if (!reset) begin
            pend[k].delete();
            x_st[k] = 0; x_chk[k] = 0; x_err[k] = 0; x_mm[k] = 1'b0;
            x_fv[k] = 1'b0; x_fe[k] = '0; x_fg[k] = '0; x_fm[k] = '0;
         end else begin
            if (en_prev) begin
               e.due = cyc + LATS[k]; e.m = modo_prev; e.v = {sb_rco, sb_q};
               pend[k].push_back(e);
            end
            hit = 0;
            if (pend[k].size() > 0 && pend[k][0].due == cyc) begin
               e = pend[k].pop_front();
               hit = 1;
            end
            if (clr_err) begin
               x_st[k] = 0; x_chk[k] = 0; x_err[k] = 0; x_mm[k] = 1'b0;
               x_fv[k] = 1'b0; x_fe[k] = '0; x_fg[k] = '0; x_fm[k] = '0;
            end else if (hit) begin
               got = {drco[k], dq[k]};
               if (x_chk[k] < 65535) x_chk[k]++;
               x_mm[k] = (got != e.v);
               if (x_mm[k]) begin
                  if (x_err[k] < (1 << EWS[k]) - 1) x_err[k]++;
                  if (!x_fv[k]) begin
                     x_fv[k] = 1'b1; x_fe[k] = e.v; x_fg[k] = got; x_fm[k] = e.m;
                  end
               end
               if (x_st[k] != 2) x_st[k] = (x_err[k] >= MAXS[k]) ? 2 : 1;
            end else begin
               x_mm[k] = 1'b0;
            end
         end
      end
      en_prev   = reset ? enable : 1'b0;
      modo_prev = modo;
      cyc++;
   endtask

   task automatic compare_all();
      for (int k = 0; k < NI; k++) begin
         check_eq($sformatf("i%0d_state", k),       32'(st_o[k]),   32'(x_st[k]));
         check_eq($sformatf("i%0d_mismatch", k),    32'(mm_o[k]),   32'(x_mm[k]));
         check_eq($sformatf("i%0d_chk_cnt", k),     32'(chk_o[k]),  32'(x_chk[k]));
         check_eq($sformatf("i%0d_err_cnt", k),     32'(err_o[k]),  32'(x_err[k]));
         check_eq($sformatf("i%0d_first_valid", k), 32'(fv_o[k]),   32'(x_fv[k]));
         check_eq($sformatf("i%0d_first_exp", k),   32'(fe_o[k]),   32'(x_fe[k]));
         check_eq($sformatf("i%0d_first_got", k),   32'(fg_o[k]),   32'(x_fg[k]));
         check_eq($sformatf("i%0d_first_modo", k),  32'(fm_o[k]),   32'(x_fm[k]));
         check_eq($sformatf("i%0d_fail", k),        32'(fail_o[k]), 32'(x_st[k] == 2));
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      if (enable) begin
         case (modo)
            2'b00:   begin sb_rco = (sb_q == 4'hF); sb_q = sb_q + 4'd1; end
            2'b01:   begin sb_rco = (sb_q == 4'h0); sb_q = sb_q - 4'd1; end
            2'b10:   begin sb_rco = (sb_q < 4'd3);  sb_q = sb_q - 4'd3; end
            default: begin sb_rco = 1'b0;           sb_q = load_d;     end
         endcase
      end
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {sb_rco, sb_q, nxt_cm, nxt_xm};
      drive_dut();
      nxt_cm = '0;
      compare_all();
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; en_prev = 1'b0; modo_prev = 2'b00;
      reset = 1'b0; enable = 1'b0; clr_err = 1'b0; modo = 2'b00; load_d = 4'h0;
      sb_q = 4'h0; sb_rco = 1'b0; nxt_cm = '0; nxt_xm = 5'h01;
      for (int i = 0; i < 4; i++) hist[i] = '0;
      drive_dut();
      tick(); tick();
      check_eq("reset_state", 32'(st_o[0]), 32'd0);
      reset = 1'b1;

      // 20 good enabled cycles, last two: load 1 then -3 (E, rco=1)
      enable = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         modo   = (i == 19) ? 2'b11 : (i == 20) ? 2'b10 : 2'b00;
         load_d = 4'h1;
         tick();
         if (i == 3) check_eq("lat2_no_cmp_yet", 32'(chk_o[1]), 32'd0);
         if (i == 4) check_eq("lat2_first_cmp", 32'(chk_o[1]), 32'd1);
      end
      enable = 1'b0;
      repeat (4) tick();
      for (int k = 0; k < NI; k++) begin
         check_eq($sformatf("good_chk_i%0d", k), 32'(chk_o[k]), 32'd20);
         check_eq($sformatf("good_err_i%0d", k), 32'(err_o[k]), 32'd0);
         check_eq($sformatf("good_state_i%0d", k), 32'(st_o[k]), 32'd1);
         check_eq($sformatf("good_fail_i%0d", k), 32'(fail_o[k]), 32'd0);
      end

      // F -> 0 with rco, instance 0 sees rco dropped
      enable = 1'b1; modo = 2'b11; load_d = 4'hF; tick();
      modo = 2'b00; nxt_cm = 3'b001; nxt_xm = 5'h10; tick();
      enable = 1'b0; tick();
      check_eq("rco_mismatch_pulse", 32'(mm_o[0]), 32'd1);
      check_eq("rco_fail_now", 32'(fail_o[0]), 32'd1);
      repeat (4) tick();
      check_eq("rco_err_cnt", 32'(err_o[0]), 32'd1);
      check_eq("rco_first_exp", 32'(fe_o[0]), 32'h10);
      check_eq("rco_first_got", 32'(fg_o[0]), 32'h00);
      check_eq("rco_first_modo", 32'(fm_o[0]), 32'd0);
      check_eq("rco_state", 32'(st_o[0]), 32'd2);

      // three corrupted loads on the MAX_ERR=3 instance
      enable = 1'b1; modo = 2'b11;
      load_d = 4'h5; nxt_cm = 3'b010; nxt_xm = 5'h01; tick();
      load_d = 4'h9; nxt_cm = 3'b010; nxt_xm = 5'h01; tick();
      load_d = 4'hA; nxt_cm = 3'b010; nxt_xm = 5'h01; tick();
      enable = 1'b0;
      repeat (5) tick();
      check_eq("max3_err_cnt", 32'(err_o[1]), 32'd3);
      check_eq("max3_first_exp", 32'(fe_o[1]), 32'h05);
      check_eq("max3_first_got", 32'(fg_o[1]), 32'h04);
      check_eq("max3_first_modo", 32'(fm_o[1]), 32'd3);
      check_eq("max3_fail", 32'(fail_o[1]), 32'd1);

      // clr_err on the same edge as a mismatching compare
      enable = 1'b1; modo = 2'b00; nxt_cm = 3'b001; nxt_xm = 5'h03; tick();
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      check_eq("clr_err_cnt", 32'(err_o[0]), 32'd0);
      check_eq("clr_mismatch", 32'(mm_o[0]), 32'd0);
      check_eq("clr_first_valid", 32'(fv_o[0]), 32'd0);
      check_eq("clr_state", 32'(st_o[0]), 32'd0);
      tick();
      check_eq("clr_back_to_check", 32'(st_o[0]), 32'd1);
      enable = 1'b0;
      repeat (4) tick();

      // put LAT3 instance in FAIL, then reset with corrupt samples in flight
      enable = 1'b1; modo = 2'b00;
      repeat (7) begin nxt_cm = 3'b100; nxt_xm = 5'h08; tick(); end
      check_eq("lat3_in_fail", 32'(st_o[2]), 32'd2);
      reset = 1'b0; tick();
      check_eq("rst_state", 32'(st_o[2]), 32'd0);
      check_eq("rst_chk_cnt", 32'(chk_o[2]), 32'd0);
      reset = 1'b1; enable = 1'b0;
      repeat (6) tick();
      check_eq("rst_no_stale_chk", 32'(chk_o[2]), 32'd0);
      check_eq("rst_no_stale_err", 32'(err_o[2]), 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         reset   = ($urandom_range(0, 99) != 0);
         clr_err = ($urandom_range(0, 49) == 0);
         enable  = ($urandom_range(0, 9) < 7);
         modo    = 2'($urandom_range(0, 3));
         load_d  = 4'($urandom_range(0, 15));
         nxt_cm  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         nxt_xm  = 5'($urandom_range(1, 31));
         tick();
      end
      reset = 1'b1; clr_err = 1'b0; enable = 1'b0;
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
